pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Owns the program counter and sequences JumpModule. Each enabled cycle it
//   advances the PC by one word. On a control-transfer request from the decoder
//   it freezes the PC and hands the operands to JumpModule, holding them stable.
//   It waits for jump_done, loads pc_out, then resumes. A watchdog traps a
//   JumpModule that never completes.
// PARAMETERS
//   PC_W          32  width of PC and of all full-width addresses
//   RESET_PC      0   PC value loaded on reset
//   JUMP_TIMEOUT  15  cycles in WAIT without ju_done before trapping (>=1)
// PORTS
//   clk            in   1      system clock, rising edge
//   rst            in   1      asynchronous, active-high reset
//   en             in   1      run enable; low = hold PC (see WAIT rule)
//   stall          in   1      pipeline hold; PC and request sampling frozen
//   jump_req       in   1      decoder requests control transfer (level)
//   jump_kind      in   4      transfer type, forwarded as path_index
//   jump_target    in   26     instruction target field
//   reg_target     in   PC_W   register-sourced target
//   jump_ack       out  1      1-cycle pulse: request accepted, operands latched
//   ju_en          out  1      to JumpModule en
//   ju_jump        out  1      to JumpModule jump
//   ju_pc          out  PC_W   to JumpModule pc (latched PC)
//   ju_addr        out  26     to JumpModule addr (latched)
//   ju_path_index  out  4      to JumpModule path_index (latched)
//   ju_reg_addr    out  PC_W   to JumpModule reg_addr (latched)
//   ju_pc_out      in   PC_W   from JumpModule pc_out
//   ju_done        in   1      from JumpModule jump_done
//   pc             out  PC_W   current program counter
//   pc_valid       out  1      pc is a fetchable address this cycle
//   busy           out  1      transfer in progress (state WAIT)
//   timeout_err    out  1      sticky watchdog trap flag
// BEHAVIOUR
//   All outputs are registered.
//   Reset (async, any state): pc=RESET_PC, state=RUN, pc_valid=0, busy=0,
//     jump_ack=0, timeout_err=0, ju_en=0, ju_jump=0, ju_* operands=0, wdog=0.
//   FSM states: RUN, WAIT, HALT.
//   RUN:
//     - en=0 or stall=1: pc holds, pc_valid=0, jump_req ignored.
//     - en=1, stall=0, jump_req=0: pc<=pc+1, modulo 2^PC_W (wraps to 0),
//       pc_valid<=1.
//     - en=1, stall=0, jump_req=1: pc holds. Latch ju_pc<=pc,
//       ju_addr<=jump_target, ju_path_index<=jump_kind, ju_reg_addr<=reg_target.
//       Set ju_en<=1, ju_jump<=1, jump_ack<=1 (one cycle), busy<=1,
//       pc_valid<=0, wdog<=0. Next state WAIT.
//     - ju_done in RUN is spurious and ignored.
//   WAIT:
//     - ju_* operands held constant. en and stall are ignored; a transfer is
//       never aborted. jump_req is ignored (no second ack).
//     - ju_done=1: pc<=ju_pc_out, ju_en<=0, ju_jump<=0, busy<=0, pc_valid<=1.
//       Next state RUN. The first sequential increment occurs the next cycle.
//     - ju_done=0: wdog<=wdog+1. If wdog==JUMP_TIMEOUT-1: timeout_err<=1,
//       ju_en<=0, ju_jump<=0, busy<=0. Next state HALT.
//     - ju_done and timeout in the same cycle: done wins, no trap.
//   HALT: pc frozen, pc_valid=0, all requests ignored. Exit only via rst.
//   Latency: jump_req accepted -> ju_en high next edge -> pc updated on the
//     edge after ju_done is sampled. Minimum 2 cycles for the redirect.
//   Reset asserted mid-WAIT: ju_en drops immediately (async); no pc load.
// TESTING
//   1 rst then en=1 for 5 cycles, RESET_PC=0 -> pc 1,2,3,4,5; pc_valid=1.
//   2 pc=3, jump_req=1, kind=6, target=5, reg=4 -> jump_ack pulse;
//     ju_pc=3, ju_addr=5, ju_path_index=6, ju_reg_addr=4; model done after 3
//     cycles with pc_out=0x14 -> pc=0x14, busy 1->0.
//   3 stall=1 for 3 cycles in RUN with jump_req=1 -> pc and ju_en unchanged,
//     no ack. Drop stall -> ack on the next cycle.
//   4 JumpModule never asserts done, JUMP_TIMEOUT=15 -> timeout_err=1 after
//     15 WAIT cycles, ju_en=0, pc frozen. Further en/jump_req -> no change.
//   5 PC_W=4, RESET_PC=14, en=1 -> pc 15,0,1 (wrap).
//   6 rst pulsed 2 cycles into WAIT -> ju_en=0 in the same cycle;
//     pc=RESET_PC, busy=0, a late ju_done is ignored.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Decoder/JumpModule-facing signal bundle of the PC sequencer.
// The sequencer takes the slave view; the environment driving it takes the master view.
interface pc_sequencer_if #(
    parameter int PC_W = 32
);
    logic            en;
    logic            stall;
    logic            jump_req;
    logic [3:0]      jump_kind;
    logic [25:0]     jump_target;
    logic [PC_W-1:0] reg_target;
    logic            jump_ack;
    logic            ju_en;
    logic            ju_jump;
    logic [PC_W-1:0] ju_pc;
    logic [25:0]     ju_addr;
    logic [3:0]      ju_path_index;
    logic [PC_W-1:0] ju_reg_addr;
    logic [PC_W-1:0] ju_pc_out;
    logic            ju_done;
    logic [PC_W-1:0] pc;
    logic            pc_valid;
    logic            busy;
    logic            timeout_err;

    modport slave (
        input  en, stall, jump_req, jump_kind, jump_target, reg_target,
        input  ju_pc_out, ju_done,
        output jump_ack, ju_en, ju_jump, ju_pc, ju_addr, ju_path_index, ju_reg_addr,
        output pc, pc_valid, busy, timeout_err
    );

    modport master (
        output en, stall, jump_req, jump_kind, jump_target, reg_target,
        output ju_pc_out, ju_done,
        input  jump_ack, ju_en, ju_jump, ju_pc, ju_addr, ju_path_index, ju_reg_addr,
        input  pc, pc_valid, busy, timeout_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: sequential increment, hand-off of control transfers to
// JumpModule, and a watchdog that parks the sequencer if JumpModule never finishes.
module pc_sequencer #(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              JUMP_TIMEOUT = 15
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.slave  bus
);
    localparam int             WD_W    = (JUMP_TIMEOUT < 2) ? 1 : $clog2(JUMP_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(JUMP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc_d;
    logic            pc_valid_q;
    logic            busy_q;
    logic            jump_ack_q;
    logic            timeout_err_q;
    logic            ju_en_q;
    logic            ju_jump_q;
    logic [PC_W-1:0] ju_pc_q;
    logic [25:0]     ju_addr_q;
    logic [3:0]      ju_path_index_q;
    logic [PC_W-1:0] ju_reg_addr_q;
    logic [WD_W-1:0] wdog_q;

    // Wraps modulo 2^PC_W by construction.
    assign pc_inc_d = pc_q + PC_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_RUN;
            pc_q            <= RESET_PC;
            pc_valid_q      <= 1'b0;
            busy_q          <= 1'b0;
            jump_ack_q      <= 1'b0;
            timeout_err_q   <= 1'b0;
            ju_en_q         <= 1'b0;
            ju_jump_q       <= 1'b0;
            ju_pc_q         <= '0;
            ju_addr_q       <= '0;
            ju_path_index_q <= '0;
            ju_reg_addr_q   <= '0;
            wdog_q          <= '0;
        end else begin
            jump_ack_q <= 1'b0;
            unique case (state_q)
                S_RUN: begin
                    if (bus.en && !bus.stall) begin
                        if (bus.jump_req) begin
                            ju_pc_q         <= pc_q;
                            ju_addr_q       <= bus.jump_target;
                            ju_path_index_q <= bus.jump_kind;
                            ju_reg_addr_q   <= bus.reg_target;
                            ju_en_q         <= 1'b1;
                            ju_jump_q       <= 1'b1;
                            jump_ack_q      <= 1'b1;
                            busy_q          <= 1'b1;
                            pc_valid_q      <= 1'b0;
                            wdog_q          <= '0;
                            state_q         <= S_WAIT;
                        end else begin
                            pc_q       <= pc_inc_d;
                            pc_valid_q <= 1'b1;
                        end
                    end else begin
                        pc_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Completion takes priority over the watchdog expiring in the same cycle.
                    if (bus.ju_done) begin
                        pc_q       <= bus.ju_pc_out;
                        ju_en_q    <= 1'b0;
                        ju_jump_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        pc_valid_q <= 1'b1;
                        state_q    <= S_RUN;
                    end else if (wdog_q == WD_LAST) begin
                        timeout_err_q <= 1'b1;
                        ju_en_q       <= 1'b0;
                        ju_jump_q     <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= S_HALT;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                S_HALT: begin
                    pc_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.busy          = busy_q;
    assign bus.jump_ack      = jump_ack_q;
    assign bus.timeout_err   = timeout_err_q;
    assign bus.ju_en         = ju_en_q;
    assign bus.ju_jump       = ju_jump_q;
    assign bus.ju_pc         = ju_pc_q;
    assign bus.ju_addr       = ju_addr_q;
    assign bus.ju_path_index = ju_path_index_q;
    assign bus.ju_reg_addr   = ju_reg_addr_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, multi-cycle corner sequences,
// a 4-bit wrap instance, and randomized traffic against a behavioural model.
module tb_pc_sequencer;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(32)) bus ();
    pc_sequencer_if #(.PC_W(4))  sb ();

    pc_sequencer #(.PC_W(32), .RESET_PC(32'd0), .JUMP_TIMEOUT(TO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pc_sequencer #(.PC_W(4), .RESET_PC(4'd14), .JUMP_TIMEOUT(TO)) u_small (
        .clk (clk),
        .rst (rst2),
        .bus (sb)
    );

    typedef struct {
        bit          en, stall, jreq, done;
        logic [3:0]  kind;
        logic [25:0] tgt;
        logic [31:0] rga, pco;
        logic [31:0] e_pc;
        bit          e_vld, e_busy, e_ack, e_juen;
        logic [31:0] e_jpc;
        logic [25:0] e_addr;
        logic [3:0]  e_kind;
        logic [31:0] e_reg;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input bit st, input bit jr, input bit dn,
                         input logic [3:0] k, input logic [25:0] t,
                         input logic [31:0] r, input logic [31:0] po);
        bus.en = en; bus.stall = st; bus.jump_req = jr; bus.ju_done = dn;
        bus.jump_kind = k; bus.jump_target = t; bus.reg_target = r; bus.ju_pc_out = po;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Behavioural reference: plain variables describing the sequencer's observable state.
    logic [31:0] m_pc, m_jpc, m_reg;
    logic [25:0] m_addr;
    logic [3:0]  m_kind;
    bit          m_vld, m_busy, m_ack, m_juen, m_tout, m_halt;
    int          m_waited;

    task automatic model_reset();
        m_pc = 0; m_jpc = 0; m_reg = 0; m_addr = 0; m_kind = 0;
        m_vld = 0; m_busy = 0; m_ack = 0; m_juen = 0; m_tout = 0; m_halt = 0;
        m_waited = 0;
    endtask

    task automatic model_edge();
        m_ack = 0;
        if (m_halt) begin
            m_vld = 0;
        end else if (m_busy) begin
            if (bus.ju_done) begin
                m_pc = bus.ju_pc_out; m_busy = 0; m_juen = 0; m_vld = 1;
            end else begin
                m_waited++;
                if (m_waited >= TO) begin
                    m_tout = 1; m_busy = 0; m_juen = 0; m_halt = 1;
                end
            end
        end else if (!bus.en || bus.stall) begin
            m_vld = 0;
        end else if (!bus.jump_req) begin
            m_pc = m_pc + 1; m_vld = 1;
        end else begin
            m_jpc = m_pc; m_addr = bus.jump_target; m_kind = bus.jump_kind;
            m_reg = bus.reg_target;
            m_juen = 1; m_ack = 1; m_busy = 1; m_vld = 0; m_waited = 0;
        end
    endtask

    task automatic model_cmp();
        chk("rnd_pc", bus.pc, m_pc);
        chk("rnd_vld", bus.pc_valid, m_vld);
        chk("rnd_busy", bus.busy, m_busy);
        chk("rnd_ack", bus.jump_ack, m_ack);
        chk("rnd_juen", bus.ju_en, m_juen);
        chk("rnd_jujump", bus.ju_jump, m_juen);
        chk("rnd_tout", bus.timeout_err, m_tout);
        chk("rnd_jupc", bus.ju_pc, m_jpc);
        chk("rnd_addr", bus.ju_addr, m_addr);
        chk("rnd_kind", bus.ju_path_index, m_kind);
        chk("rnd_reg", bus.ju_reg_addr, m_reg);
    endtask

    initial begin
        bit stuck;
        int halted_for;

        sb.en = 0; sb.stall = 0; sb.jump_req = 0; sb.ju_done = 0;
        sb.jump_kind = 0; sb.jump_target = 0; sb.reg_target = 0; sb.ju_pc_out = 0;

        tbl[0]  = '{1,0,0,0, 0,0,0,0,        1,1,0,0,0,      0,0,0,0};
        tbl[1]  = '{1,0,0,0, 0,0,0,0,        2,1,0,0,0,      0,0,0,0};
        tbl[2]  = '{1,0,0,0, 0,0,0,0,        3,1,0,0,0,      0,0,0,0};
        tbl[3]  = '{1,0,0,0, 0,0,0,0,        4,1,0,0,0,      0,0,0,0};
        tbl[4]  = '{1,0,0,0, 0,0,0,0,        5,1,0,0,0,      0,0,0,0};
        tbl[5]  = '{1,0,1,0, 6,5,4,0,        5,0,1,1,1,      5,5,6,4};
        tbl[6]  = '{1,0,1,0, 9,9,9,0,        5,0,1,0,1,      5,5,6,4};
        tbl[7]  = '{0,1,0,0, 0,0,0,0,        5,0,1,0,1,      5,5,6,4};
        tbl[8]  = '{0,0,0,1, 0,0,0,'h14,     'h14,1,0,0,0,   5,5,6,4};
        tbl[9]  = '{1,0,0,1, 0,0,0,'hAAA,    'h15,1,0,0,0,   5,5,6,4};
        tbl[10] = '{1,1,1,0, 2,7,9,0,        'h15,0,0,0,0,   5,5,6,4};
        tbl[11] = '{1,1,1,0, 2,7,9,0,        'h15,0,0,0,0,   5,5,6,4};
        tbl[12] = '{1,1,1,0, 2,7,9,0,        'h15,0,0,0,0,   5,5,6,4};
        tbl[13] = '{1,0,1,1, 2,7,9,'h999,    'h15,0,1,1,1,   'h15,7,2,9};
        tbl[14] = '{0,0,0,1, 0,0,0,'h100,    'h100,1,0,0,0,  'h15,7,2,9};
        tbl[15] = '{0,0,0,0, 0,0,0,0,        'h100,0,0,0,0,  'h15,7,2,9};

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        chk("rst_pc", bus.pc, 0);
        chk("rst_vld", bus.pc_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ack", bus.jump_ack, 0);
        chk("rst_juen", bus.ju_en, 0);
        chk("rst_tout", bus.timeout_err, 0);
        chk("rst_jupc", bus.ju_pc, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].stall, tbl[i].jreq, tbl[i].done,
                  tbl[i].kind, tbl[i].tgt, tbl[i].rga, tbl[i].pco);
            step();
            chk($sformatf("v%0d_pc", i), bus.pc, tbl[i].e_pc);
            chk($sformatf("v%0d_vld", i), bus.pc_valid, tbl[i].e_vld);
            chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].e_busy);
            chk($sformatf("v%0d_ack", i), bus.jump_ack, tbl[i].e_ack);
            chk($sformatf("v%0d_juen", i), bus.ju_en, tbl[i].e_juen);
            chk($sformatf("v%0d_jujump", i), bus.ju_jump, tbl[i].e_juen);
            chk($sformatf("v%0d_jupc", i), bus.ju_pc, tbl[i].e_jpc);
            chk($sformatf("v%0d_addr", i), bus.ju_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_kind", i), bus.ju_path_index, tbl[i].e_kind);
            chk($sformatf("v%0d_reg", i), bus.ju_reg_addr, tbl[i].e_reg);
        end

        // Watchdog trap after JUMP_TIMEOUT silent WAIT cycles, then HALT is sticky.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 1, 0, 3, 8, 1, 0);
        step();
        chk("to_ack", bus.jump_ack, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= TO; i++) begin
            step();
            if (i == TO - 1) begin
                chk("to_busy_before", bus.busy, 1);
                chk("to_tout_before", bus.timeout_err, 0);
            end
        end
        chk("to_tout", bus.timeout_err, 1);
        chk("to_juen", bus.ju_en, 0);
        chk("to_busy", bus.busy, 0);
        chk("to_pc", bus.pc, 1);
        drive(1, 0, 1, 1, 1, 1, 1, 'h55);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt_pc", bus.pc, 1);
            chk("halt_ack", bus.jump_ack, 0);
            chk("halt_vld", bus.pc_valid, 0);
            chk("halt_tout", bus.timeout_err, 1);
        end

        // Done arriving on the last watchdog cycle wins.
        do_reset();
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) step();
        drive(0, 0, 0, 1, 0, 0, 0, 'h40);
        step();
        chk("race_tout", bus.timeout_err, 0);
        chk("race_pc", bus.pc, 'h40);
        chk("race_busy", bus.busy, 0);
        chk("race_vld", bus.pc_valid, 1);

        // Async reset in the middle of WAIT; a later done must not load the PC.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_juen", bus.ju_en, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_pc", bus.pc, 0);
        step();
        rst = 1'b0;
        drive(0, 0, 0, 1, 0, 0, 0, 'h77);
        step();
        chk("arst_late_done_pc", bus.pc, 0);
        chk("arst_late_done_juen", bus.ju_en, 0);

        // 4-bit PC wrap from RESET_PC=14.
        sb.en = 1'b1;
        rst2 = 1'b1;
        step();
        chk("wrap_rst", sb.pc, 14);
        rst2 = 1'b0;
        step();
        chk("wrap_15", sb.pc, 15);
        step();
        chk("wrap_0", sb.pc, 0);
        step();
        chk("wrap_1", sb.pc, 1);
        sb.en = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        stuck = 0;
        halted_for = 0;
        for (int n = 0; n < 1500; n++) begin
            bit dn;
            if (m_halt && halted_for >= 3) begin
                do_reset();
                model_reset();
                halted_for = 0;
                model_cmp();
            end
            dn = m_busy ? (!stuck && ($urandom % 4 == 0)) : ($urandom % 8 == 0);
            drive(($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 3) == 0, dn,
                  4'($urandom), 26'($urandom), $urandom, $urandom);
            step();
            model_edge();
            if (m_ack) stuck = ($urandom % 6) == 0;
            if (m_halt) halted_for++;
            model_cmp();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
